memory_port_arbiter: RTL and testbench

//   Shares the single main-memory port between the I-cache and D-cache refill/writeback ports.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_perf_counters.sv | 26 ++
 rtl/memory_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic MST_ICACHE = 1'b0;
    localparam logic MST_DCACHE = 1'b1;

    // Ceiling log2, never below 1 so a zero-length counter cannot occur.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_arb_perf_counters.sv
// Grant and wait-cycle counters for the memory port arbiter.
module mem_arb_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done_i,
    input  logic        done_d,
    input  logic        wait_i,
    input  logic        wait_d,
    output logic [31:0] grant_i,
    output logic [31:0] grant_d,
    output logic [31:0] wait_cycles
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_i     <= '0;
            grant_d     <= '0;
            wait_cycles <= '0;
        end else begin
            grant_i     <= grant_i + 32'(done_i);
            grant_d     <= grant_d + 32'(done_d);
            wait_cycles <= wait_cycles + 32'(wait_i) + 32'(wait_d);
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing the memory port between I-cache and D-cache.
// Define MEM_ARB_PERF_EN to add grant and wait-cycle performance counters.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   icache_mem_addr,
    input  logic                icache_mem_req,
    output logic [DATA_W-1:0]   icache_mem_rdata,
    output logic                icache_mem_ready,
    input  logic [ADDR_W-1:0]   dcache_mem_addr,
    input  logic [DATA_W-1:0]   dcache_mem_wdata,
    input  logic [DATA_W/8-1:0] dcache_mem_be,
    input  logic                dcache_mem_we,
    input  logic                dcache_mem_req,
    output logic [DATA_W-1:0]   dcache_mem_rdata,
    output logic                dcache_mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_we,
    output logic                mem_req,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]         perf_grant_i,
    output logic [31:0]         perf_grant_d,
    output logic [31:0]         perf_wait_cycles,
`endif
    output logic                timeout_err
);

    localparam int WD_W = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e      state;
    arb_state_e      state_next;
    logic            rr_last;
    logic            rr_next;
    logic [WD_W-1:0] wd_cnt;
    logic            busy;
    logic            wd_clear;
    logic            wd_hit;

    assign icache_mem_rdata = mem_rdata;
    assign dcache_mem_rdata = mem_rdata;

    always_comb begin
        state_next = state;
        rr_next    = rr_last;
        unique case (state)
            IDLE: begin
                if (icache_mem_req && dcache_mem_req) begin
                    state_next = (rr_last == MST_ICACHE) ? BUSY_D : BUSY_I;
                end else if (dcache_mem_req) begin
                    state_next = BUSY_D;
                end else if (icache_mem_req) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    rr_next    = MST_ICACHE;
                    state_next = dcache_mem_req ? BUSY_D : IDLE;
                end else if (!icache_mem_req) begin
                    state_next = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    rr_next    = MST_DCACHE;
                    state_next = icache_mem_req ? BUSY_I : IDLE;
                end else if (!dcache_mem_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter restarts whenever a new transaction begins or one completes.
    assign busy     = (state != IDLE);
    assign wd_clear = !busy || mem_ready || (state_next != state);
    assign wd_hit   = (TIMEOUT_CYCLES != 0) && busy && !mem_ready &&
                      (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_last     <= MST_ICACHE;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_next;
            rr_last <= rr_next;
            if (wd_clear) begin
                wd_cnt <= '0;
            end else if (!(&wd_cnt)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_req          = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        mem_be           = '0;
        mem_we           = 1'b0;
        icache_mem_ready = 1'b0;
        dcache_mem_ready = 1'b0;
        unique case (state)
            BUSY_I: begin
                mem_req          = icache_mem_req;
                mem_addr         = icache_mem_addr;
                icache_mem_ready = mem_ready;
            end
            BUSY_D: begin
                mem_req          = dcache_mem_req;
                mem_addr         = dcache_mem_addr;
                mem_wdata        = dcache_mem_wdata;
                mem_be           = dcache_mem_be;
                mem_we           = dcache_mem_we;
                dcache_mem_ready = mem_ready;
            end
            default: begin
            end
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .done_i      (icache_mem_ready),
        .done_d      (dcache_mem_ready),
        .wait_i      (icache_mem_req && (state != BUSY_I)),
        .wait_d      (dcache_mem_req && (state != BUSY_D)),
        .grant_i     (perf_grant_i),
        .grant_d     (perf_grant_d),
        .wait_cycles (perf_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: transaction-level model plus directed scenarios.
module tb_memory_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] iaddr = '0;
    logic          ireq = 1'b0;
    logic [DW-1:0] irdata;
    logic          iready;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic [3:0]    dbe = '0;
    logic          dwe = 1'b0;
    logic          dreq = 1'b0;
    logic [DW-1:0] drdata;
    logic          dready;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [3:0]    mbe;
    logic          mwe;
    logic          mreq;
    logic [DW-1:0] mrdata = '0;
    logic          mready = 1'b0;
    logic          terr;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   pgi;
    logic [31:0]   pgd;
    logic [31:0]   pwait;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    memory_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_mem_addr(iaddr), .icache_mem_req(ireq),
        .icache_mem_rdata(irdata), .icache_mem_ready(iready),
        .dcache_mem_addr(daddr), .dcache_mem_wdata(dwdata),
        .dcache_mem_be(dbe), .dcache_mem_we(dwe), .dcache_mem_req(dreq),
        .dcache_mem_rdata(drdata), .dcache_mem_ready(dready),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_be(mbe), .mem_we(mwe),
        .mem_req(mreq), .mem_rdata(mrdata), .mem_ready(mready),
`ifdef MEM_ARB_PERF_EN
        .perf_grant_i(pgi), .perf_grant_d(pgd), .perf_wait_cycles(pwait),
`endif
        .timeout_err(terr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: owner 0=nobody 1=icache 2=dcache; last = most recently served.
    int owner = 0;
    int last = 1;
    int age = 0;
    bit err = 1'b0;
    int m_gi = 0;
    int m_gd = 0;
    int m_wait = 0;
    bit own_req;
    bit oth_req;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = 0; last = 1; age = 0; err = 1'b0;
            m_gi = 0; m_gd = 0; m_wait = 0;
        end else begin
            m_wait += ((ireq && owner != 1) ? 1 : 0) + ((dreq && owner != 2) ? 1 : 0);
            if (owner == 0) begin
                age = 0;
                if (ireq && dreq) owner = (last == 1) ? 2 : 1;
                else if (dreq) owner = 2;
                else if (ireq) owner = 1;
            end else begin
                own_req = (owner == 1) ? ireq : dreq;
                oth_req = (owner == 1) ? dreq : ireq;
                if (mready) begin
                    if (owner == 1) m_gi++; else m_gd++;
                    last = owner;
                    owner = oth_req ? 3 - owner : 0;
                    age = 0;
                end else begin
                    if (TO != 0 && age + 1 >= TO) err = 1'b1;
                    if (!own_req) begin owner = 0; age = 0; end
                    else age++;
                end
            end
        end
    end

    logic          e_req, e_we, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [3:0]    e_be;

    always @(negedge clk) begin
        if (chk_en) begin
            e_req   = (owner == 1) ? ireq : (owner == 2) ? dreq : 1'b0;
            e_addr  = (owner == 1) ? iaddr : (owner == 2) ? daddr : '0;
            e_wdata = (owner == 2) ? dwdata : '0;
            e_be    = (owner == 2) ? dbe : '0;
            e_we    = (owner == 2) ? dwe : 1'b0;
            e_ir    = (owner == 1) && mready;
            e_dr    = (owner == 2) && mready;
            chk("m_mem_req", 64'(mreq), 64'(e_req));
            chk("m_mem_addr", 64'(maddr), 64'(e_addr));
            chk("m_mem_wdata", 64'(mwdata), 64'(e_wdata));
            chk("m_mem_be", 64'(mbe), 64'(e_be));
            chk("m_mem_we", 64'(mwe), 64'(e_we));
            chk("m_iready", 64'(iready), 64'(e_ir));
            chk("m_dready", 64'(dready), 64'(e_dr));
            chk("m_irdata", 64'(irdata), 64'(mrdata));
            chk("m_drdata", 64'(drdata), 64'(mrdata));
            chk("m_timeout", 64'(terr), 64'(err));
`ifdef MEM_ARB_PERF_EN
            chk("m_perf_gi", 64'(pgi), 64'(m_gi));
            chk("m_perf_gd", 64'(pgd), 64'(m_gd));
            chk("m_perf_wait", 64'(pwait), 64'(m_wait));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ireq = 1'b0; dreq = 1'b0; mready = 1'b0; dwe = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int order[8];
    int done;
    int w;

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_mem_req", 64'(mreq), 64'd0);
        chk("rst_timeout", 64'(terr), 64'd0);

        // Single D-cache write
        daddr = 32'h100; dwe = 1'b1; dbe = 4'hF; dwdata = 32'hDEADBEEF;
        mrdata = 32'h12345678; dreq = 1'b1;
        tick();
        chk("s1_mem_req", 64'(mreq), 64'd1);
        chk("s1_mem_addr", 64'(maddr), 64'h100);
        chk("s1_mem_we", 64'(mwe), 64'd1);
        chk("s1_mem_be", 64'(mbe), 64'hF);
        chk("s1_mem_wdata", 64'(mwdata), 64'hDEADBEEF);
        tick();
        mready = 1'b1;
        #1;
        chk("s1_dready", 64'(dready), 64'd1);
        chk("s1_iready", 64'(iready), 64'd0);
        chk("s1_drdata", 64'(drdata), 64'h12345678);
        tick();
        dreq = 1'b0; mready = 1'b0;
        #1;
        chk("s1_idle_req", 64'(mreq), 64'd0);
        chk("s1_idle_addr", 64'(maddr), 64'd0);

        // Simultaneous requests: D first, then I with no bubble
        do_reset();
        iaddr = 32'h200; daddr = 32'h300; dwe = 1'b0;
        ireq = 1'b1; dreq = 1'b1;
        tick();
        chk("s2_first_addr", 64'(maddr), 64'h300);
        mready = 1'b1;
        #1;
        chk("s2_dready", 64'(dready), 64'd1);
        tick();
        dreq = 1'b0; mready = 1'b0;
        #1;
        chk("s2_second_req", 64'(mreq), 64'd1);
        chk("s2_second_addr", 64'(maddr), 64'h200);
        mready = 1'b1;
        #1;
        chk("s2_iready", 64'(iready), 64'd1);
        tick();
        ireq = 1'b0; mready = 1'b0;

        // Both held continuously, memory ready two cycles after mem_req
        do_reset();
        iaddr = 32'h1000; daddr = 32'h2000; dwe = 1'b0;
        ireq = 1'b1; dreq = 1'b1;
        done = 0; w = 0;
        for (int c = 0; c < 100 && done < 8; c++) begin
            if (mreq && w == 1) begin
                mready = 1'b1; w = 0;
            end else begin
                mready = 1'b0;
                if (mreq) w = 1;
            end
            #1;
            if (dready) begin order[done] = 2; done++; end
            else if (iready) begin order[done] = 1; done++; end
            if (done < 8) tick();
        end
        chk("s3_completions", 64'(done), 64'd8);
        tick();
        ireq = 1'b0; dreq = 1'b0; mready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s3_order", 64'(order[k]), (k % 2 == 0) ? 64'd2 : 64'd1);
        end
        chk("s3_model_gi", 64'(m_gi), 64'd4);
        chk("s3_model_gd", 64'(m_gd), 64'd4);
        tick();
        tick();
`ifdef MEM_ARB_PERF_EN
        chk("s6_perf_gi", 64'(pgi), 64'd4);
        chk("s6_perf_gd", 64'(pgd), 64'd4);
        chk("s6_perf_wait", 64'(pwait), 64'd18);
`endif
        chk("s3_model_wait", 64'(m_wait), 64'd18);
        mready = 1'b1;
        #1;
        chk("idle_ready_i", 64'(iready), 64'd0);
        chk("idle_ready_d", 64'(dready), 64'd0);
        tick();
        mready = 1'b0;

        // Watchdog
        do_reset();
        iaddr = 32'h400; ireq = 1'b1;
        tick();
        repeat (15) tick();
        chk("s4_before", 64'(terr), 64'd0);
        tick();
        chk("s4_at", 64'(terr), 64'd1);
        repeat (5) tick();
        chk("s4_sticky", 64'(terr), 64'd1);
        chk("s4_still_req", 64'(mreq), 64'd1);
        ireq = 1'b0; rst_n = 1'b0;
        #1;
        chk("s4_rst_clear", 64'(terr), 64'd0);
        chk("s4_rst_req", 64'(mreq), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("s4_idle", 64'(mreq), 64'd0);

        // Reset in the middle of a D-cache transaction
        do_reset();
        daddr = 32'h500; dwe = 1'b0; dreq = 1'b1;
        tick();
        tick();
        chk("s5_busy", 64'(mreq), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("s5_req_drop", 64'(mreq), 64'd0);
        mready = 1'b1;
        #1;
        chk("s5_no_ready", 64'(dready), 64'd0);
        tick();
        rst_n = 1'b1; dreq = 1'b0; mready = 1'b0;
        tick();
        chk("s5_idle", 64'(mreq), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
